if_fetch_buf: RTL and testbench
===============================

Name: if_fetch_buf

Overview:
- Instruction-fetch stage that sits directly downstream of the PC register and ends at the decode stage.
- Consumes the PC register's `pc`/`ce` outputs and issues req/ack read requests to a variable-latency instruction ROM.
- Buffers returned instructions in a small FIFO and drives the IF/ID pipeline register outputs to ID.
- Raises `stallreq_if` to CTRL whenever it cannot accept the presented PC, so the PC freezes instead of skipping.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
pc  in  32  fetch address from PC register
ce  in  1  PC valid / fetch enable from PC register
stall  in  6  CTRL stall vector; bit0 PC, bit1 IF, bit2 ID
flush  in  1  synchronous pipeline flush from CTRL
rom_req  out  1  instruction ROM request
rom_addr  out  32  instruction ROM address
rom_ack  in  1  ROM data valid, may assert in the first cycle rom_req is high
rom_data  in  32  ROM read data, valid when rom_ack=1
id_pc  out  32  IF/ID register: instruction address
id_inst  out  32  IF/ID register: instruction word
id_valid  out  1  IF/ID register: entry valid
stallreq_if  out  1  combinational stall request to CTRL

Behaviour:
- Reset: clocked on clk; rst synchronous, active-high. All outputs 0, state IDLE, FIFO pointers and count 0. Reset overrides flush and every other input, including mid-request; any outstanding ROM ack is ignored after reset.
- Accept condition: `accept = ce & ~stall[0] & ~flush & (state==IDLE | (state==WAIT & rom_ack))`.
- Slot accounting: `used = count + (state==WAIT)`.
- stallreq_if: combinational, `ce & (flush | state==DRAIN | (state==WAIT & ~rom_ack) | used==DEPTH)`. It is 0 whenever ce=0. CTRL turns it into stall[0]=1 in the same cycle, so a PC is never dropped.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE:
  - accept -> latch `rom_addr<=pc`, `rom_req<=1`, go to WAIT.
- WAIT:
  - rom_req and rom_addr held stable until rom_ack.
  - On rom_ack: push {rom_addr, rom_data}. If accept in the same cycle, relaunch with the new pc and stay in WAIT (back-to-back). Otherwise drop rom_req and go to IDLE.
  - flush without ack -> DRAIN.
  - flush with ack -> data discarded, go to IDLE.
- DRAIN:
  - Keep rom_req high, discard data on rom_ack, then go to IDLE.
- FIFO:
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leaves count unchanged.
  - The slot reservation (`used`) guarantees a push never finds the FIFO full. A pop does not free a slot for acceptance in the same cycle (conservative).
- IF/ID register, evaluated each edge in priority order:
  1. flush -> id_* = 0; FIFO cleared.
  2. stall[1]=1, stall[2]=0 -> bubble (id_* = 0), no pop.
  3. stall[1]=1, stall[2]=1 -> hold id_*, no pop.
  4. stall[1]=0, FIFO non-empty -> pop head into id_pc/id_inst, id_valid=1.
  5. stall[1]=0, FIFO empty -> bubble.
- Latency: pc accepted at edge E0; rom_req high after E0. With ack in that cycle, push occurs at E1 and id_valid=1 after E2. Zero-wait throughput is one instruction per cycle.

Test Plan:
1. Zero-wait ROM (ack = req, same cycle), stall=0 -> rom_addr 0,4,8,C on consecutive cycles; id_pc 0,4,8,C with id_valid=1 starting two edges after the first accept; stallreq_if never 1.
2. ROM ack on the 3rd cycle of each request -> stallreq_if=1 for 2 cycles per fetch, rom_addr stable across each request; id_pc sequence 0,4,8 with no gaps or duplicates.
3. stall[2:1]=11 for 8 cycles, zero-wait ROM, DEPTH=4 -> stallreq_if rises once used=4; id_* hold; after release, id_pc continues strictly +4 with no loss.
4. stall[2:1]=01 for one cycle -> id_valid=0, id_inst=0 that cycle; the next cycle the un-popped head appears.
5. flush while WAIT, ack 2 cycles later -> rom_req held high, rom_addr unchanged, returned data never reaches id_*; FIFO empty, id_valid=0; stallreq_if=1 until the ack cycle, then fetch resumes from the current pc.
6. rst asserted during WAIT -> after the next edge rom_req=0, rom_addr=0, id_*=0, count=0, state IDLE; a late rom_ack is ignored.

Source files
------------

// File: rtl/if_fetch_buf_if.sv
// Bundle of the PC-side, ROM-side and IF/ID-side signals of the fetch buffer.
// The dbg_* fields expose internal state for checkers and benches.
interface if_fetch_buf_if;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        stallreq_if;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_count;

  // Fetch-stage side.
  modport slave (
    input  pc, ce, stall, flush, rom_ack, rom_data,
    output rom_req, rom_addr, id_pc, id_inst, id_valid, stallreq_if,
    output dbg_state, dbg_count
  );

  // Environment side: PC register, CTRL, ROM and ID observer.
  modport master (
    output pc, ce, stall, flush, rom_ack, rom_data,
    input  rom_req, rom_addr, id_pc, id_inst, id_valid, stallreq_if,
    input  dbg_state, dbg_count
  );
endinterface

// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage: issues req/ack reads to a variable-latency ROM,
// buffers returned words in a small FIFO and drives the IF/ID register.
module if_fetch_buf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic          clk,
  input logic          rst,
  if_fetch_buf_if.slave bus
);

  // Handshakes: a PC is taken when ce=1 and stall[0]=0 (CTRL mirrors
  // stallreq_if onto stall[0]); a ROM read holds rom_req and rom_addr
  // stable until the cycle rom_ack=1, which completes it in that same cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic              rom_req_q, rom_req_d;
  logic [31:0]       rom_addr_q, rom_addr_d;

  logic [31:0]       mem_pc   [DEPTH];
  logic [31:0]       mem_inst [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, used;

  logic [31:0]       id_pc_q, id_inst_q;
  logic              id_valid_q;

  logic              accept, push, pop, fifo_empty, stallreq;
  logic              unused_stall;

  assign unused_stall = ^bus.stall[5:3];

  always_comb begin
    fifo_empty = (count_q == '0);
    // An in-flight request owns a FIFO slot, so its push can never overflow.
    used       = count_q + (PTR_W + 1)'(state_q == WAIT);
    accept     = bus.ce & ~bus.stall[0] & ~bus.flush &
                 ((state_q == IDLE) | ((state_q == WAIT) & bus.rom_ack));
    push       = (state_q == WAIT) & bus.rom_ack & ~bus.flush;
    pop        = ~bus.flush & ~bus.stall[1] & ~fifo_empty;
    stallreq   = bus.ce & (bus.flush | (state_q == DRAIN) |
                           ((state_q == WAIT) & ~bus.rom_ack) | (used == FULL));
  end

  // Request FSM: next state and ROM request registers.
  always_comb begin
    state_d    = state_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = WAIT;
          rom_req_d  = 1'b1;
          rom_addr_d = bus.pc;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          if (bus.rom_ack) begin
            state_d   = IDLE;
            rom_req_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (bus.rom_ack) begin
          if (accept) begin
            rom_addr_d = bus.pc;
          end else begin
            state_d   = IDLE;
            rom_req_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        // The ROM cannot cancel a read, so wait out the ack and drop the data.
        if (bus.rom_ack) begin
          state_d   = IDLE;
          rom_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        rom_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= rom_addr_q;
      mem_inst[wr_ptr_q] <= bus.rom_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // IF/ID register: flush, then bubble (stall IF only), then hold, then pop.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else if (bus.stall[1] && !bus.stall[2]) begin
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else if (bus.stall[1]) begin
      id_pc_q    <= id_pc_q;
      id_inst_q  <= id_inst_q;
      id_valid_q <= id_valid_q;
    end else if (pop) begin
      id_pc_q    <= mem_pc[rd_ptr_q];
      id_inst_q  <= mem_inst[rd_ptr_q];
      id_valid_q <= 1'b1;
    end else begin
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && count_q == FULL));
    end
  end

  assign bus.rom_req     = rom_req_q;
  assign bus.rom_addr    = rom_addr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_inst     = id_inst_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.stallreq_if = stallreq;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_count   = 8'(count_q);

endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: acts as PC register, CTRL and a latency-configurable
// ROM, and scoreboards the IF/ID stream against the queue of accepted PCs.
module tb_if_fetch_buf;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st_pc = 1'b0, st_if = 1'b0, st_id = 1'b0, force_ack = 1'b0;
  int   lat_lo = 0, lat_hi = 0;
  int   n_vec = 0, n_err = 0;
  int   n_pop = 0;
  logic [31:0] exp_q[$];

  logic        rom_busy = 1'b0;
  int          rom_wait = 0;
  logic [31:0] rom_hold = '0;
  logic        last_sreq = 1'b0;

  if_fetch_buf_if bus();

  if_fetch_buf #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // CTRL: stallreq_if freezes the PC in the same cycle.
  assign bus.stall = {3'b000, st_id, st_if, bus.stallreq_if | st_pc};

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // One clock: ROM response, pre-edge snapshot, edge, scoreboard update.
  task automatic cycle();
    logic        s_rst, s_flush, s_acc, s_ce, s_sreq, p_valid;
    logic [1:0]  s_st;
    logic [31:0] p_pc, p_inst, s_pc, want;
    if (force_ack) begin
      bus.rom_ack  = 1'b1;
      bus.rom_data = $urandom;
    end else if (bus.rom_req === 1'b1) begin
      if (!rom_busy) begin
        rom_busy = 1'b1;
        rom_wait = $urandom_range(lat_hi, lat_lo);
        rom_hold = bus.rom_addr;
      end else begin
        n_vec++;
        if (bus.rom_addr !== rom_hold) begin
          n_err++;
          $display("FAIL rom_addr_stable: got %h want %h", bus.rom_addr, rom_hold);
        end
      end
      if (rom_wait == 0) begin
        bus.rom_ack  = 1'b1;
        bus.rom_data = inst_of(bus.rom_addr);
        rom_busy     = 1'b0;
      end else begin
        bus.rom_ack  = 1'b0;
        bus.rom_data = $urandom;
        rom_wait--;
      end
    end else begin
      rom_busy     = 1'b0;
      bus.rom_ack  = 1'b0;
      bus.rom_data = '0;
    end
    #1;
    s_rst   = rst;
    s_flush = bus.flush;
    s_ce    = bus.ce;
    s_sreq  = bus.stallreq_if;
    s_st    = {st_id, st_if};
    s_pc    = bus.pc;
    s_acc   = !rst && bus.ce && !bus.stall[0] && !bus.flush;
    p_valid = bus.id_valid;
    p_pc    = bus.id_pc;
    p_inst  = bus.id_inst;
    if (!s_ce) begin
      n_vec++;
      if (s_sreq !== 1'b0) begin
        n_err++;
        $display("FAIL stallreq_ce0: got %b want 0", s_sreq);
      end
    end
    @(posedge clk);
    #1;
    if (s_rst || s_flush) exp_q.delete();
    n_vec++;
    if (s_rst || s_flush || s_st == 2'b01) begin
      if ({bus.id_valid, bus.id_pc, bus.id_inst} !== 65'b0) begin
        n_err++;
        $display("FAIL id_clear: got v=%b pc=%h inst=%h want zeros",
                 bus.id_valid, bus.id_pc, bus.id_inst);
      end
    end else if (s_st == 2'b11) begin
      if ({bus.id_valid, bus.id_pc, bus.id_inst} !== {p_valid, p_pc, p_inst}) begin
        n_err++;
        $display("FAIL id_hold: got v=%b pc=%h want v=%b pc=%h",
                 bus.id_valid, bus.id_pc, p_valid, p_pc);
      end
    end else if (bus.id_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL id_spurious: got pc=%h want no instruction", bus.id_pc);
      end else begin
        want = exp_q.pop_front();
        n_pop++;
        if (bus.id_pc !== want || bus.id_inst !== inst_of(want)) begin
          n_err++;
          $display("FAIL id_stream: got pc=%h inst=%h want pc=%h inst=%h",
                   bus.id_pc, bus.id_inst, want, inst_of(want));
        end
      end
    end else if ({bus.id_valid, bus.id_pc, bus.id_inst} !== 65'b0) begin
      n_err++;
      $display("FAIL id_bubble: got v=%b pc=%h inst=%h want zeros",
               bus.id_valid, bus.id_pc, bus.id_inst);
    end
    if (s_acc) begin
      exp_q.push_back(s_pc);
      bus.pc = s_pc + 32'd4;
    end
    n_vec++;
    if (!(bus.dbg_count <= DEPTH)) begin
      n_err++;
      $display("FAIL fifo_bound: got %0d want <= %0d", bus.dbg_count, DEPTH);
    end
    last_sreq = s_sreq;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bus.ce    = 1'b0;
    bus.flush = 1'b0;
    st_pc = 1'b0; st_if = 1'b0; st_id = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ce = 1'b0; bus.flush = 1'b0; bus.pc = '0;
    st_pc = 1'b0; st_if = 1'b0; st_id = 1'b0; force_ack = 1'b0;
    lat_lo = 0; lat_hi = 0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ce = 1'b0; bus.flush = 1'b0; bus.pc = '0;
    bus.rom_ack = 1'b0; bus.rom_data = '0;
    cycle();
    cycle();
    n_vec++;
    if ({bus.rom_req, bus.rom_addr, bus.id_valid, bus.id_pc, bus.id_inst} !== 98'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b addr=%h v=%b want zeros",
               bus.rom_req, bus.rom_addr, bus.id_valid);
    end
    n_vec++;
    if (bus.dbg_state !== 2'd0 || bus.dbg_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_state: got st=%0d cnt=%0d want 0 0", bus.dbg_state, bus.dbg_count);
    end
    n_vec++;
    if (bus.stallreq_if !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stallreq: got %b want 0", bus.stallreq_if);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_reset();
    bus.ce = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      n_vec++;
      if (bus.rom_req !== 1'b1 || bus.rom_addr !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL zw_rom_addr: got req=%b addr=%h want 1 %h", bus.rom_req, bus.rom_addr, 4 * k);
      end
      n_vec++;
      if (last_sreq !== 1'b0) begin
        n_err++;
        $display("FAIL zw_stallreq: got %b want 0 (k=%0d)", last_sreq, k);
      end
      n_vec++;
      if (bus.id_valid !== (k >= 2) || (k >= 2 && bus.id_pc !== 32'(4 * (k - 2)))) begin
        n_err++;
        $display("FAIL zw_latency: got v=%b pc=%h at k=%0d", bus.id_valid, bus.id_pc, k);
      end
    end
    idle_cycles(6);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL zw_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_slow_rom();
    int p0;
    do_reset();
    lat_lo = 2; lat_hi = 2;
    p0 = n_pop;
    bus.ce = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      n_vec++;
      if (last_sreq !== (k % 3 != 0)) begin
        n_err++;
        $display("FAIL slow_stallreq: got %b want %b at k=%0d", last_sreq, (k % 3 != 0), k);
      end
    end
    idle_cycles(10);
    n_vec++;
    if (n_pop - p0 != 3 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL slow_count: got %0d delivered want 3", n_pop - p0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.ce = 1'b1;
    repeat (4) cycle();
    st_if = 1'b1; st_id = 1'b1;
    for (int s = 0; s < 8; s++) begin
      cycle();
      n_vec++;
      if (last_sreq !== (s >= 2)) begin
        n_err++;
        $display("FAIL bp_stallreq: got %b want %b at s=%0d", last_sreq, (s >= 2), s);
      end
    end
    n_vec++;
    if (bus.dbg_count !== 8'd4 || bus.dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL bp_full: got cnt=%0d st=%0d want 4 0", bus.dbg_count, bus.dbg_state);
    end
    st_if = 1'b0; st_id = 1'b0;
    repeat (6) cycle();
    idle_cycles(10);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_bubble();
    logic [31:0] head;
    do_reset();
    bus.ce = 1'b1;
    repeat (4) cycle();
    head  = exp_q[0];
    st_if = 1'b1;
    cycle();
    n_vec++;
    if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'd0) begin
      n_err++;
      $display("FAIL bubble_zero: got v=%b inst=%h want 0 0", bus.id_valid, bus.id_inst);
    end
    st_if = 1'b0;
    cycle();
    n_vec++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== head) begin
      n_err++;
      $display("FAIL bubble_head: got v=%b pc=%h want 1 %h", bus.id_valid, bus.id_pc, head);
    end
    idle_cycles(8);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bubble_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    int p0;
    do_reset();
    lat_lo = 2; lat_hi = 2;
    p0 = n_pop;
    bus.ce = 1'b1;
    cycle();
    for (int k = 1; k < 4; k++) begin
      bus.flush = (k == 1);
      cycle();
      n_vec++;
      if (last_sreq !== 1'b1 || bus.id_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_stall: got sreq=%b v=%b want 1 0 at k=%0d", last_sreq, bus.id_valid, k);
      end
      n_vec++;
      if (k < 3 && (bus.rom_req !== 1'b1 || bus.rom_addr !== 32'd0 || bus.dbg_state !== 2'd2)) begin
        n_err++;
        $display("FAIL flush_drain: got req=%b addr=%h st=%0d want 1 0 2", bus.rom_req, bus.rom_addr, bus.dbg_state);
      end
    end
    n_vec++;
    if (bus.rom_req !== 1'b0 || bus.dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL flush_idle: got req=%b st=%0d want 0 0", bus.rom_req, bus.dbg_state);
    end
    cycle();
    n_vec++;
    if (last_sreq !== 1'b0 || bus.rom_req !== 1'b1 || bus.rom_addr !== 32'd4) begin
      n_err++;
      $display("FAIL flush_resume: got sreq=%b req=%b addr=%h want 0 1 4", last_sreq, bus.rom_req, bus.rom_addr);
    end
    idle_cycles(10);
    n_vec++;
    if (n_pop - p0 != 1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL flush_count: got %0d delivered want 1", n_pop - p0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.ce = 1'b1;
    st_if = 1'b1; st_id = 1'b1;
    repeat (3) cycle();
    lat_lo = 5; lat_hi = 5;
    st_if = 1'b0; st_id = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    n_vec++;
    if ({bus.rom_req, bus.rom_addr, bus.id_valid, bus.id_pc, bus.id_inst} !== 98'b0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got req=%b addr=%h v=%b want zeros", bus.rom_req, bus.rom_addr, bus.id_valid);
    end
    n_vec++;
    if (bus.dbg_state !== 2'd0 || bus.dbg_count !== 8'd0) begin
      n_err++;
      $display("FAIL rstmid_state: got st=%0d cnt=%0d want 0 0", bus.dbg_state, bus.dbg_count);
    end
    rst = 1'b0;
    bus.ce = 1'b0;
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    cycle();
    cycle();
    n_vec++;
    if (bus.dbg_state !== 2'd0 || bus.dbg_count !== 8'd0 || bus.id_valid !== 1'b0 || bus.rom_req !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_late_ack: got st=%0d cnt=%0d v=%b req=%b want 0 0 0 0",
               bus.dbg_state, bus.dbg_count, bus.id_valid, bus.rom_req);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 400; i++) begin
      bus.ce    = ($urandom_range(9, 0) != 0);
      st_pc     = ($urandom_range(9, 0) == 0);
      bus.flush = ($urandom_range(29, 0) == 0);
      if (bus.flush) bus.pc = $urandom & 32'hffff_fffc;
      r = $urandom_range(9, 0);
      {st_id, st_if} = (r < 6) ? 2'b00 : (r < 8) ? 2'b11 : (r < 9) ? 2'b01 : 2'b10;
      cycle();
    end
    idle_cycles(20);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_slow_rom();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
